ifu_fetch: RTL and testbench

Instruction fetch unit for the MIPS-lite datapath. It owns the architectural PC register, issues word reads to instruction memory over a request/grant handshake, and buffers returned instructions in a small queue toward decode. It consumes the next-PC stage's output as a redirect target and exports the current fetch PC back to it.

---
 rtl/mips_lite_pkg.sv | 20 ++
 rtl/ifu_fetch_if.sv | 27 ++
 rtl/ifu_queue.sv | 67 ++++++
 rtl/ifu_fetch.sv | 118 +++++++++++
 tb/tb_ifu_fetch.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_lite_pkg.sv
// Shared fetch-side types and constants for the MIPS-lite datapath.
// Provides the reset PC default, word-align mask and fetch FSM states.
package mips_lite_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } fetch_state_e;

  function automatic logic [31:0] word_align(
    input logic [31:0] a
  );
    return a & WORD_MASK;
  endfunction

endpackage

// File: rtl/ifu_fetch_if.sv
// Instruction memory request/grant bus between fetch and imem.
// master: fetch side (req/addr out); slave: memory side.
interface ifu_fetch_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/ifu_queue.sv
// Synchronous FIFO with flush; head is presented combinationally.
// Ports: push/din, pop/dout, flush, count, full, empty.
module ifu_queue #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [AW-1:0] nxt(
    input logic [AW-1:0] p
  );
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= nxt(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= nxt(rd_ptr);
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ifu_fetch.sv
// Fetch unit: PC register, imem req/gnt issue, in-order tag FIFO and
// instruction queue to decode; redirects flush and drain stale reads.
module ifu_fetch
  import mips_lite_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] fetch_pc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  ifu_fetch_if.master imem,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  input  logic        id_ready
);

  localparam int CW = $clog2(QDEPTH + 1);

  fetch_state_e state;

  logic [CW-1:0] outstanding;
  logic [CW-1:0] q_count;
  logic [CW:0]   inflight;
  logic          t_full;
  logic          t_empty;
  logic          q_full;
  logic          q_empty;
  logic [31:0]   t_pc;
  logic [63:0]   q_dout;
  logic          grant;
  logic          rv;
  logic          keep;
  logic          drain_go;

  // Cap covers both queued and in-flight words so a
  // returning response always has a queue slot.
  assign inflight = {1'b0, outstanding} + {1'b0, q_count};

  assign imem.imem_req = (state == RUN) && !redirect
                      && !t_full && !q_full
                      && (inflight < (CW + 1)'(QDEPTH));
  assign imem.imem_addr = fetch_pc;

  assign grant = imem.imem_req && imem.imem_gnt;
  // rvalid with nothing in flight is ignored.
  assign rv    = imem.imem_rvalid && !t_empty;
  // In DRAIN every response is stale; redirect kills the
  // coincident response too.
  assign keep  = rv && (state == RUN) && !redirect;

  // Responses still owed after this cycle's rvalid.
  assign drain_go = (outstanding > CW'(rv));

  // Tag FIFO count doubles as the outstanding counter.
  ifu_queue #(
    .DEPTH(QDEPTH),
    .WIDTH(32)
  ) u_tag (
    .clk  (clk),
    .rst_n(rst_n),
    .flush(1'b0),
    .push (grant),
    .din  (fetch_pc),
    .pop  (rv),
    .dout (t_pc),
    .count(outstanding),
    .full (t_full),
    .empty(t_empty)
  );

  ifu_queue #(
    .DEPTH(QDEPTH),
    .WIDTH(64)
  ) u_iq (
    .clk  (clk),
    .rst_n(rst_n),
    .flush(redirect),
    .push (keep),
    .din  ({t_pc, imem.imem_rdata}),
    .pop  (id_ready),
    .dout (q_dout),
    .count(q_count),
    .full (q_full),
    .empty(q_empty)
  );

  assign id_valid = !q_empty;
  assign id_pc    = q_dout[63:32];
  assign id_instr = q_dout[31:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
    end else begin
      if (redirect) begin
        fetch_pc <= word_align(redirect_pc);
      end else if (grant) begin
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (redirect) begin
        state <= drain_go ? DRAIN : RUN;
      end else begin
        unique case (state)
          IDLE:    state <= RUN;
          RUN:     state <= RUN;
          DRAIN:   state <= drain_go ? DRAIN : RUN;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch with a simple in-order imem model.
// Checks reset, streaming, backpressure, redirect/drain, wrap, async reset.
module tb_ifu_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] fetch_pc;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        id_ready = 1'b0;

  ifu_fetch_if bus();

  ifu_fetch u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fetch_pc   (fetch_pc),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem       (bus),
    .id_valid   (id_valid),
    .id_instr   (id_instr),
    .id_pc      (id_pc),
    .id_ready   (id_ready)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  int          grants = 0;
  int          got;
  bit          resp_on = 1'b0;
  logic [31:0] pend[$];
  logic [31:0] pcs[4];
  logic [31:0] ins[4];

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'h5A5A_5A5A;
  endfunction

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_resp();
    bus.imem_rvalid = resp_on && (pend.size() > 0);
    bus.imem_rdata  = (pend.size() > 0) ? mem(pend[0]) : 32'h0;
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic step();
    logic        g;
    logic        r;
    logic [31:0] a;
    #1;
    g = bus.imem_req && bus.imem_gnt;
    r = bus.imem_rvalid;
    a = bus.imem_addr;
    @(posedge clk);
    #1;
    if (r && pend.size() > 0) void'(pend.pop_front());
    if (g) begin
      pend.push_back(a);
      grants++;
    end
    drive_resp();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    redirect      = 1'b0;
    bus.imem_gnt  = 1'b0;
    id_ready      = 1'b0;
    resp_on       = 1'b0;
    pend.delete();
    drive_resp();
    step();
    step();
    rst_n  = 1'b1;
    grants = 0;
  endtask

  task automatic collect(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < 30 && cnt < n; i++) begin
      if (id_valid && id_ready) begin
        pcs[cnt] = id_pc;
        ins[cnt] = id_instr;
        cnt++;
      end
      step();
    end
  endtask

  initial begin
    @(negedge clk);
    // Reset values
    rst_n        = 1'b0;
    bus.imem_gnt = 1'b0;
    pend.delete();
    drive_resp();
    step();
    step();
    chk("rst_req", {31'b0, bus.imem_req}, 32'h0);
    chk("rst_addr", bus.imem_addr, 32'h0000_3000);
    chk("rst_fpc", fetch_pc, 32'h0000_3000);
    chk("rst_idv", {31'b0, id_valid}, 32'h0);
    chk("rst_instr", id_instr, 32'h0);
    chk("rst_idpc", id_pc, 32'h0);
    rst_n = 1'b1;

    // Streaming with gnt=1, one-cycle response, decode ready
    bus.imem_gnt = 1'b1;
    id_ready     = 1'b1;
    resp_on      = 1'b1;
    step();
    chk("s1_req", {31'b0, bus.imem_req}, 32'h1);
    chk("s1_addr", bus.imem_addr, 32'h0000_3000);
    collect(3, got);
    chk("s1_pops", got, 3);
    chk("s1_pc0", pcs[0], 32'h0000_3000);
    chk("s1_pc1", pcs[1], 32'h0000_3004);
    chk("s1_pc2", pcs[2], 32'h0000_3008);
    chk("s1_in0", ins[0], 32'h5A5A_6A5A);
    chk("s1_in2", ins[2], 32'h5A5A_6A52);

    // Decode stalled: cap at two fetches
    do_reset();
    bus.imem_gnt = 1'b1;
    resp_on      = 1'b1;
    repeat (8) step();
    chk("s2_grants", grants, 2);
    chk("s2_req", {31'b0, bus.imem_req}, 32'h0);
    chk("s2_idv", {31'b0, id_valid}, 32'h1);
    chk("s2_idpc", id_pc, 32'h0000_3000);
    chk("s2_instr", id_instr, 32'h5A5A_6A5A);
    id_ready = 1'b1;
    step();
    id_ready = 1'b0;
    chk("s2_idpc2", id_pc, 32'h0000_3004);

    // Redirect with two outstanding -> DRAIN
    do_reset();
    bus.imem_gnt = 1'b1;
    id_ready     = 1'b1;
    step();
    step();
    step();
    chk("s3_grants", grants, 2);
    chk("s3_req0", {31'b0, bus.imem_req}, 32'h0);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_3043;
    step();
    redirect = 1'b0;
    chk("s3_fpc", fetch_pc, 32'h0000_3040);
    resp_on = 1'b1;
    drive_resp();
    step();
    chk("s3_dr_idv", {31'b0, id_valid}, 32'h0);
    chk("s3_dr_req", {31'b0, bus.imem_req}, 32'h0);
    step();
    chk("s3_idv", {31'b0, id_valid}, 32'h0);
    chk("s3_req1", {31'b0, bus.imem_req}, 32'h1);
    chk("s3_addr", bus.imem_addr, 32'h0000_3040);
    for (int i = 0; i < 10 && !id_valid; i++) step();
    chk("s3_wait", {31'b0, id_valid}, 32'h1);
    chk("s3_idpc", id_pc, 32'h0000_3040);
    chk("s3_instr", id_instr, 32'h5A5A_6A1A);

    // Redirect coinciding with rvalid and a pending req
    do_reset();
    bus.imem_gnt = 1'b1;
    id_ready     = 1'b1;
    resp_on      = 1'b1;
    step();
    step();
    redirect    = 1'b1;
    redirect_pc = 32'h0000_5000;
    #1;
    chk("s4_retract", {31'b0, bus.imem_req}, 32'h0);
    step();
    redirect = 1'b0;
    #1;
    chk("s4_idv", {31'b0, id_valid}, 32'h0);
    chk("s4_fpc", fetch_pc, 32'h0000_5000);
    chk("s4_req", {31'b0, bus.imem_req}, 32'h1);
    step();
    chk("s4_idv2", {31'b0, id_valid}, 32'h0);

    // PC wrap
    do_reset();
    bus.imem_gnt = 1'b1;
    id_ready     = 1'b1;
    resp_on      = 1'b1;
    step();
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0;
    chk("s5_fpc", fetch_pc, 32'hFFFF_FFFC);
    collect(2, got);
    chk("s5_pops", got, 2);
    chk("s5_pc0", pcs[0], 32'hFFFF_FFFC);
    chk("s5_pc1", pcs[1], 32'h0000_0000);
    chk("s5_in0", ins[0], 32'hA5A5_A5A6);
    chk("s5_in1", ins[1], 32'h5A5A_5A5A);

    // Async reset in DRAIN
    do_reset();
    bus.imem_gnt = 1'b1;
    resp_on      = 1'b1;
    step();
    step();
    step();
    resp_on = 1'b0;
    drive_resp();
    redirect    = 1'b1;
    redirect_pc = 32'h0000_7000;
    step();
    redirect = 1'b0;
    chk("s6_fpc", fetch_pc, 32'h0000_7000);
    chk("s6_req", {31'b0, bus.imem_req}, 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("s6_rfpc", fetch_pc, 32'h0000_3000);
    chk("s6_raddr", bus.imem_addr, 32'h0000_3000);
    chk("s6_rreq", {31'b0, bus.imem_req}, 32'h0);
    chk("s6_ridv", {31'b0, id_valid}, 32'h0);
    chk("s6_ridpc", id_pc, 32'h0);
    pend.delete();
    drive_resp();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("s6_req1", {31'b0, bus.imem_req}, 32'h1);
    chk("s6_addr1", bus.imem_addr, 32'h0000_3000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
